// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: FSM state codes, lamp encodings, driver modes and
// sequence/lamp helpers used by the lamp driver.
package tl_pkg;

  localparam logic [2:0] ST_START = 3'b111;
  localparam logic [2:0] ST_NS    = 3'b011;
  localparam logic [2:0] ST_NY    = 3'b010;
  localparam logic [2:0] ST_EW    = 3'b000;
  localparam logic [2:0] ST_EY    = 3'b001;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] MODE_FLASH = 2'd0;
  localparam logic [1:0] MODE_CLEAR = 2'd1;
  localparam logic [1:0] MODE_RUN   = 2'd2;
  localparam logic [1:0] MODE_FAULT = 2'd3;

  // True when moving from prev to cur is an allowed step of the light sequence.
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    ok = 1'b0;
    if (cur == 3'b100 || cur == 3'b101 || cur == 3'b110) begin
      ok = 1'b0;
    end else if (cur == prev || cur == ST_START) begin
      ok = 1'b1;
    end else begin
      case (prev)
        ST_NS:    ok = (cur == ST_NY);
        ST_NY:    ok = (cur == ST_EW);
        ST_EW:    ok = (cur == ST_EY);
        ST_EY:    ok = (cur == ST_NS);
        ST_START: ok = (cur == ST_NS);
        default:  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Steady-state {ns, ew} lamps for a running state code.
  function automatic logic [5:0] run_lamps(input logic [2:0] code);
    logic [5:0] lamps;
    case (code)
      ST_NS:   lamps = {LAMP_G, LAMP_R};
      ST_NY:   lamps = {LAMP_Y, LAMP_R};
      ST_EW:   lamps = {LAMP_R, LAMP_G};
      ST_EY:   lamps = {LAMP_R, LAMP_Y};
      default: lamps = {LAMP_R, LAMP_R};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tl_lamp_driver_if.sv
// Lamp-driver bus: state code and pedestrian requests in, lamp/walk/wait/fault drives out.
interface tl_lamp_driver_if;

  logic [2:0] state;
  logic       ped_req_ns;
  logic       ped_req_ew;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       walk_ns;
  logic       walk_ew;
  logic       wait_ns;
  logic       wait_ew;
  logic       fault;

  modport master (
    output state, ped_req_ns, ped_req_ew,
    input  ns_lamp, ew_lamp, walk_ns, walk_ew, wait_ns, wait_ew, fault
  );

  modport slave (
    input  state, ped_req_ns, ped_req_ew,
    output ns_lamp, ew_lamp, walk_ns, walk_ew, wait_ns, wait_ew, fault
  );

endinterface

// File: rtl/tl_blinker.sv
// Reload-and-toggle blink generator. o_phase is the phase that will be held after the
// coming edge, so callers can fold it straight into registered outputs.
module tl_blinker #(
  parameter int unsigned          CNT_WIDTH  = 8,
  parameter logic [CNT_WIDTH-1:0] BLINK_HALF = CNT_WIDTH'(4)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_phase
);

  localparam logic [CNT_WIDTH-1:0] Reload = BLINK_HALF - CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_restart) begin
      cnt_d   = Reload;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = Reload;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_d;

endmodule

// File: rtl/tl_lamp_driver.sv
// Converts the traffic-light FSM state code into registered lamp, walk and wait drives,
// with all-red clearance, yellow flash on START and a sticky red-flash fault mode.
module tl_lamp_driver
  import tl_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH  = 8,
  parameter logic [CNT_WIDTH-1:0] BLINK_HALF = CNT_WIDTH'(4),
  parameter logic [CNT_WIDTH-1:0] CLR_TIME   = CNT_WIDTH'(2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  tl_lamp_driver_if.slave  bus
);

  logic [1:0]           mode_q, mode_d;
  logic [2:0]           prev_q, prev_d;
  logic [CNT_WIDTH-1:0] clr_q, clr_d;
  logic                 restart, phase, enter_green;
  logic [2:0]           ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
  logic                 fault_q;
  // Index 0 is the NS crossing, index 1 the EW crossing.
  logic [1:0]           req, green_q, green_d, walk_q, walk_d, wait_q, wait_d;
  logic                 ignore_req;

  tl_blinker #(
    .CNT_WIDTH  (CNT_WIDTH),
    .BLINK_HALF (BLINK_HALF)
  ) u_blinker (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (restart),
    .o_phase   (phase)
  );

  always_comb begin
    mode_d      = mode_q;
    prev_d      = prev_q;
    clr_d       = clr_q;
    restart     = 1'b0;
    enter_green = 1'b0;
    if (mode_q == MODE_FAULT) begin
      if (bus.state == ST_START) begin
        mode_d  = MODE_FLASH;
        prev_d  = ST_START;
        restart = 1'b1;
      end
    end else if (!legal_step(prev_q, bus.state)) begin
      mode_d  = MODE_FAULT;
      restart = 1'b1;
    end else if (bus.state == ST_START) begin
      mode_d  = MODE_FLASH;
      prev_d  = ST_START;
      restart = (mode_q != MODE_FLASH);
    end else begin
      prev_d      = bus.state;
      enter_green = (bus.state != prev_q) && (bus.state == ST_NS || bus.state == ST_EW);
      if (enter_green) begin
        if (CLR_TIME == '0) begin
          mode_d = MODE_RUN;
        end else begin
          mode_d = MODE_CLEAR;
          clr_d  = CLR_TIME - CNT_WIDTH'(1);
        end
      end else if (mode_q == MODE_CLEAR) begin
        // A non-green step during clearance only updates prev_state; the count runs on.
        if (clr_q == '0) begin
          mode_d = MODE_RUN;
        end else begin
          clr_d = clr_q - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign req        = {bus.ped_req_ew, bus.ped_req_ns};
  assign green_q    = {mode_q == MODE_RUN && prev_q == ST_EW, mode_q == MODE_RUN && prev_q == ST_NS};
  assign green_d    = {mode_d == MODE_RUN && prev_d == ST_EW, mode_d == MODE_RUN && prev_d == ST_NS};
  assign ignore_req = (mode_q == MODE_FAULT) || (mode_d == MODE_FAULT);

  always_comb begin
    walk_d = walk_q;
    wait_d = wait_q;
    for (int i = 0; i < 2; i++) begin
      if (ignore_req) begin
        walk_d[i] = 1'b0;
        wait_d[i] = 1'b0;
      end else if (green_d[i] && !green_q[i] && wait_q[i]) begin
        // Grant at green entry; a request in the same cycle is absorbed by this grant.
        walk_d[i] = 1'b1;
        wait_d[i] = 1'b0;
      end else begin
        walk_d[i] = walk_q[i] && green_d[i];
        wait_d[i] = wait_q[i] || req[i];
      end
    end
  end

  always_comb begin
    ns_lamp_d = LAMP_R;
    ew_lamp_d = LAMP_R;
    unique case (mode_d)
      MODE_FLASH: begin
        ns_lamp_d = phase ? LAMP_Y : LAMP_OFF;
        ew_lamp_d = phase ? LAMP_Y : LAMP_OFF;
      end
      MODE_CLEAR: begin
        ns_lamp_d = LAMP_R;
        ew_lamp_d = LAMP_R;
      end
      MODE_RUN: {ns_lamp_d, ew_lamp_d} = run_lamps(prev_d);
      MODE_FAULT: begin
        ns_lamp_d = phase ? LAMP_R : LAMP_OFF;
        ew_lamp_d = phase ? LAMP_R : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q    <= MODE_FLASH;
      prev_q    <= ST_START;
      clr_q     <= '0;
      ns_lamp_q <= LAMP_R;
      ew_lamp_q <= LAMP_R;
      walk_q    <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      clr_q     <= clr_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
      walk_q    <= walk_d;
      wait_q    <= wait_d;
      fault_q   <= (mode_d == MODE_FAULT);
    end
  end

  assign bus.ns_lamp = ns_lamp_q;
  assign bus.ew_lamp = ew_lamp_q;
  assign bus.walk_ns = walk_q[0];
  assign bus.walk_ew = walk_q[1];
  assign bus.wait_ns = wait_q[0];
  assign bus.wait_ew = wait_q[1];
  assign bus.fault   = fault_q;

endmodule
